reorder_buffer: RTL and testbench

Circular reorder buffer that hands out ROB ids to the dispatch stage, collects results from the ALU and MEM common data buses, and retires instructions in program order to the register file. It closes the tag loop used by the reservation stations: the stations wait on ROB ids, and the execution units broadcast results under those ids. This block issues the ids, answers operand lookups for them, and frees them in order. ROB id 0 is reserved as "none/invalid" and is never allocated.

---
 rtl/reorder_buffer_if.sv | 52 +++++
 rtl/reorder_buffer.sv | 131 +++++++++++++
 tb/tb_reorder_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Bundle of dispatch, operand-lookup, result-broadcast and retire signals
// between the reorder buffer and the rest of the out-of-order core.
//
// Handshake semantics: the only flow-controlled transfer is allocation.
// An allocation transfers on a rising clk_in edge when alloc_valid=1 and
// has_no_vacancy=0 at that edge. The transferred entry's id is the alloc_id
// seen in that cycle. When has_no_vacancy=1 the request is dropped rather than
// stalled, so dispatch must check has_no_vacancy before asserting alloc_valid.
// CDB broadcasts and commits are unconditional one-cycle pulses with no
// back-pressure. Id 0 on any tag means "none".
interface reorder_buffer_if #(
   parameter int ROB_ID_WIDTH = 4
);
   logic                    flush_input;
   logic                    alloc_valid;
   logic [4:0]              alloc_rd;
   logic [ROB_ID_WIDTH-1:0] alloc_id;
   logic                    has_no_vacancy;
   logic                    has_one_vacancy;
   logic [ROB_ID_WIDTH-1:0] query_j_id;
   logic [ROB_ID_WIDTH-1:0] query_k_id;
   logic                    query_j_ready;
   logic                    query_k_ready;
   logic [31:0]             query_j_value;
   logic [31:0]             query_k_value;
   logic [ROB_ID_WIDTH-1:0] cdb_alu_rob_id;
   logic [ROB_ID_WIDTH-1:0] cdb_mem_rob_id;
   logic [31:0]             cdb_alu_value;
   logic [31:0]             cdb_mem_value;
   logic                    commit_valid;
   logic [ROB_ID_WIDTH-1:0] commit_rob_id;
   logic [4:0]              commit_rd;
   logic [31:0]             commit_value;

   // Core side: dispatch, stations and execution units.
   modport master (
      output flush_input, alloc_valid, alloc_rd, query_j_id, query_k_id,
             cdb_alu_rob_id, cdb_mem_rob_id, cdb_alu_value, cdb_mem_value,
      input  alloc_id, has_no_vacancy, has_one_vacancy,
             query_j_ready, query_k_ready, query_j_value, query_k_value,
             commit_valid, commit_rob_id, commit_rd, commit_value
   );

   // Reorder buffer side.
   modport slave (
      input  flush_input, alloc_valid, alloc_rd, query_j_id, query_k_id,
             cdb_alu_rob_id, cdb_mem_rob_id, cdb_alu_value, cdb_mem_value,
      output alloc_id, has_no_vacancy, has_one_vacancy,
             query_j_ready, query_k_ready, query_j_value, query_k_value,
             commit_valid, commit_rob_id, commit_rd, commit_value
   );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: issues ROB ids 1..2^W-1 (0 is "none"), captures
// results from the ALU and MEM result buses, forwards operands to the
// reservation stations and retires one instruction per cycle in order.
module reorder_buffer #(
   parameter int ROB_ID_WIDTH = 4
) (
   input logic             clk_in,
   input logic             rst_n_in,
   reorder_buffer_if.slave rob
);
   localparam int DEPTH = 2 ** ROB_ID_WIDTH;
   typedef logic [ROB_ID_WIDTH-1:0] id_t;
   localparam id_t MAX_ID = '1;
   localparam id_t ONE_ID = id_t'(1);

   // Entry 0 exists only so tags index the arrays directly; it is never used.
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] ready_q;
   logic [4:0]       rd_q    [DEPTH];
   logic [31:0]      value_q [DEPTH];

   id_t         head_q;
   id_t         tail_q;
   id_t         count_q;
   logic        commit_valid_q;
   id_t         commit_rob_id_q;
   logic [4:0]  commit_rd_q;
   logic [31:0] commit_value_q;

   logic alloc_ok;
   logic commit_ok;

   // Pointers skip id 0 when wrapping.
   function automatic id_t next_ptr(input id_t p);
      return (p == MAX_ID) ? ONE_ID : p + ONE_ID;
   endfunction

   assign rob.has_no_vacancy  = (count_q == MAX_ID);
   assign rob.has_one_vacancy = (count_q == MAX_ID - ONE_ID);
   assign rob.alloc_id        = tail_q;
   assign alloc_ok            = rob.alloc_valid && !rob.has_no_vacancy;
   assign commit_ok           = busy_q[head_q] && ready_q[head_q];

   assign rob.commit_valid  = commit_valid_q;
   assign rob.commit_rob_id = commit_rob_id_q;
   assign rob.commit_rd     = commit_rd_q;
   assign rob.commit_value  = commit_value_q;

   // Operand lookup: tag 0, then same-cycle bus forwarding (ALU first), then stored result.
   always_comb begin
      rob.query_j_ready = 1'b0;
      rob.query_j_value = 32'd0;
      rob.query_k_ready = 1'b0;
      rob.query_k_value = 32'd0;
      if (rob.query_j_id == '0) begin
         rob.query_j_ready = 1'b1;
      end else if (rob.query_j_id == rob.cdb_alu_rob_id) begin
         rob.query_j_ready = 1'b1;
         rob.query_j_value = rob.cdb_alu_value;
      end else if (rob.query_j_id == rob.cdb_mem_rob_id) begin
         rob.query_j_ready = 1'b1;
         rob.query_j_value = rob.cdb_mem_value;
      end else if (busy_q[rob.query_j_id] && ready_q[rob.query_j_id]) begin
         rob.query_j_ready = 1'b1;
         rob.query_j_value = value_q[rob.query_j_id];
      end
      if (rob.query_k_id == '0) begin
         rob.query_k_ready = 1'b1;
      end else if (rob.query_k_id == rob.cdb_alu_rob_id) begin
         rob.query_k_ready = 1'b1;
         rob.query_k_value = rob.cdb_alu_value;
      end else if (rob.query_k_id == rob.cdb_mem_rob_id) begin
         rob.query_k_ready = 1'b1;
         rob.query_k_value = rob.cdb_mem_value;
      end else if (busy_q[rob.query_k_id] && ready_q[rob.query_k_id]) begin
         rob.query_k_ready = 1'b1;
         rob.query_k_value = value_q[rob.query_k_id];
      end
   end

   // Entry state, pointers, occupancy and registered commit port.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in || rob.flush_input) begin
         head_q          <= ONE_ID;
         tail_q          <= ONE_ID;
         count_q         <= '0;
         busy_q          <= '0;
         ready_q         <= '0;
         commit_valid_q  <= 1'b0;
         commit_rob_id_q <= '0;
         commit_rd_q     <= '0;
         commit_value_q  <= '0;
      end else begin
         // MEM is written first so a same-id ALU broadcast overrides it.
         if (rob.cdb_mem_rob_id != '0 && busy_q[rob.cdb_mem_rob_id]) begin
            ready_q[rob.cdb_mem_rob_id] <= 1'b1;
            value_q[rob.cdb_mem_rob_id] <= rob.cdb_mem_value;
         end
         if (rob.cdb_alu_rob_id != '0 && busy_q[rob.cdb_alu_rob_id]) begin
            ready_q[rob.cdb_alu_rob_id] <= 1'b1;
            value_q[rob.cdb_alu_rob_id] <= rob.cdb_alu_value;
         end
         // The tail entry is never busy when an alloc is accepted, so no bus write can collide.
         if (alloc_ok) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            rd_q[tail_q]    <= rob.alloc_rd;
            tail_q          <= next_ptr(tail_q);
         end
         if (commit_ok) begin
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
            head_q          <= next_ptr(head_q);
            commit_valid_q  <= 1'b1;
            commit_rob_id_q <= head_q;
            commit_rd_q     <= rd_q[head_q];
            commit_value_q  <= value_q[head_q];
         end else begin
            commit_valid_q  <= 1'b0;
            commit_rob_id_q <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
         end
         unique case ({alloc_ok, commit_ok})
            2'b10:   count_q <= count_q + ONE_ID;
            2'b01:   count_q <= count_q - ONE_ID;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, in-order retirement, full/wrap,
// commit-vs-alloc collision, operand forwarding, flush and back-to-back flow.
module tb_reorder_buffer;
   logic clk_in = 1'b0;
   logic rst_n_in;
   int   vectors = 0;
   int   errors  = 0;
   logic [40:0] exp_q[$];

   reorder_buffer_if #(.ROB_ID_WIDTH(4)) rob ();

   reorder_buffer #(.ROB_ID_WIDTH(4)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rob      (rob.slave)
   );

   // Clock: active edge is posedge; the bench drives and samples on negedge.
   always #5 clk_in = ~clk_in;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic drive_idle();
      rob.flush_input    = 1'b0;
      rob.alloc_valid    = 1'b0;
      rob.alloc_rd       = 5'd0;
      rob.query_j_id     = 4'd0;
      rob.query_k_id     = 4'd0;
      rob.cdb_alu_rob_id = 4'd0;
      rob.cdb_mem_rob_id = 4'd0;
      rob.cdb_alu_value  = 32'd0;
      rob.cdb_mem_value  = 32'd0;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      drive_idle();
      rob.alloc_valid = 1'b1;
      rob.alloc_rd    = 5'd5;
      step();
      step();
      rst_n_in = 1'b1;
      drive_idle();
      rob.query_j_id = 4'd1;
      #1;
      vectors++; if (rob.alloc_id !== 4'd1) begin errors++; $display("FAIL reset_alloc_id got %0d want 1", rob.alloc_id); end
      vectors++; if (rob.has_no_vacancy !== 1'b0) begin errors++; $display("FAIL reset_no_vacancy got %b want 0", rob.has_no_vacancy); end
      vectors++; if (rob.has_one_vacancy !== 1'b0) begin errors++; $display("FAIL reset_one_vacancy got %b want 0", rob.has_one_vacancy); end
      vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %b want 0", rob.commit_valid); end
      vectors++; if (rob.query_j_ready !== 1'b0) begin errors++; $display("FAIL reset_lookup_id1 ready got %b want 0", rob.query_j_ready); end
      vectors++; if (rob.query_k_ready !== 1'b1 || rob.query_k_value !== 32'd0) begin errors++; $display("FAIL reset_lookup_tag0 got ready=%b value=%h want ready=1 value=0", rob.query_k_ready, rob.query_k_value); end
      drive_idle();
   endtask

   task automatic test_in_order();
      logic [40:0] got;
      logic [40:0] exp;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (rob.alloc_id !== 4'(i + 1)) begin errors++; $display("FAIL order_alloc_id got %0d want %0d", rob.alloc_id, i + 1); end
         rob.alloc_valid = 1'b1;
         rob.alloc_rd    = 5'(5 + i);
         step();
      end
      drive_idle();
      exp_q.push_back({4'd1, 5'd5, 32'h11});
      exp_q.push_back({4'd2, 5'd6, 32'h22});
      exp_q.push_back({4'd3, 5'd7, 32'h33});
      rob.cdb_alu_rob_id = 4'd2; rob.cdb_alu_value = 32'h22;
      step();
      vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL order_early_commit_a got %b want 0", rob.commit_valid); end
      rob.cdb_alu_rob_id = 4'd1; rob.cdb_alu_value = 32'h11;
      step();
      vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL order_early_commit_b got %b want 0", rob.commit_valid); end
      rob.cdb_alu_rob_id = 4'd3; rob.cdb_alu_value = 32'h33;
      rob.query_j_id = 4'd2;
      #1;
      vectors++; if (rob.query_j_ready !== 1'b1 || rob.query_j_value !== 32'h22) begin errors++; $display("FAIL order_stored_lookup got ready=%b value=%h want ready=1 value=22", rob.query_j_ready, rob.query_j_value); end
      step();
      drive_idle();
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         if (rob.commit_valid === 1'b1) begin
            got = {rob.commit_rob_id, rob.commit_rd, rob.commit_value};
            exp = exp_q.pop_front();
            vectors++; if (got !== exp) begin errors++; $display("FAIL order_commit got id=%0d rd=%0d val=%h want id=%0d rd=%0d val=%h", got[40:37], got[36:32], got[31:0], exp[40:37], exp[36:32], exp[31:0]); end
         end
         step();
      end
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL order_commit_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); end
      vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL order_idle_after got %b want 0", rob.commit_valid); end
   endtask

   // Starts empty with head=tail=4; fills ids 4..15,1,2,3.
   task automatic test_full();
      logic [3:0] exp_id = 4'd4;
      for (int i = 0; i < 15; i++) begin
         vectors++; if (rob.alloc_id !== exp_id) begin errors++; $display("FAIL full_alloc_id step %0d got %0d want %0d", i, rob.alloc_id, exp_id); end
         if (i == 13) begin
            vectors++; if (rob.has_one_vacancy !== 1'b0) begin errors++; $display("FAIL full_one_vac_13 got %b want 0", rob.has_one_vacancy); end
         end
         if (i == 14) begin
            vectors++; if (rob.has_one_vacancy !== 1'b1 || rob.has_no_vacancy !== 1'b0) begin errors++; $display("FAIL full_one_vac_14 got one=%b none=%b want one=1 none=0", rob.has_one_vacancy, rob.has_no_vacancy); end
         end
         rob.alloc_valid = 1'b1;
         rob.alloc_rd    = {1'b0, exp_id};
         step();
         exp_id = (exp_id == 4'd15) ? 4'd1 : 4'(exp_id + 4'd1);
      end
      vectors++; if (rob.has_no_vacancy !== 1'b1 || rob.has_one_vacancy !== 1'b0) begin errors++; $display("FAIL full_flags got none=%b one=%b want none=1 one=0", rob.has_no_vacancy, rob.has_one_vacancy); end
      vectors++; if (rob.alloc_id !== 4'd4) begin errors++; $display("FAIL full_tail got %0d want 4", rob.alloc_id); end
      rob.alloc_rd = 5'd30;
      step();
      vectors++; if (rob.has_no_vacancy !== 1'b1 || rob.alloc_id !== 4'd4) begin errors++; $display("FAIL full_drop got none=%b id=%0d want none=1 id=4", rob.has_no_vacancy, rob.alloc_id); end
      drive_idle();
   endtask

   task automatic test_simultaneous();
      rob.cdb_alu_rob_id = 4'd4; rob.cdb_alu_value = 32'h44;
      step();
      drive_idle();
      rob.alloc_valid = 1'b1;
      rob.alloc_rd    = 5'd9;
      vectors++; if (rob.commit_valid !== 1'b0 || rob.has_no_vacancy !== 1'b1) begin errors++; $display("FAIL simul_pre got commit=%b none=%b want commit=0 none=1", rob.commit_valid, rob.has_no_vacancy); end
      step();
      vectors++; if (rob.commit_valid !== 1'b1 || rob.commit_rob_id !== 4'd4 || rob.commit_rd !== 5'd4 || rob.commit_value !== 32'h44) begin errors++; $display("FAIL simul_commit got v=%b id=%0d rd=%0d val=%h want v=1 id=4 rd=4 val=44", rob.commit_valid, rob.commit_rob_id, rob.commit_rd, rob.commit_value); end
      vectors++; if (rob.has_no_vacancy !== 1'b0 || rob.has_one_vacancy !== 1'b1 || rob.alloc_id !== 4'd4) begin errors++; $display("FAIL simul_rejected got none=%b one=%b id=%0d want none=0 one=1 id=4", rob.has_no_vacancy, rob.has_one_vacancy, rob.alloc_id); end
      step();
      drive_idle();
      vectors++; if (rob.has_no_vacancy !== 1'b1 || rob.alloc_id !== 4'd5 || rob.commit_valid !== 1'b0) begin errors++; $display("FAIL simul_accepted got none=%b id=%0d commit=%b want none=1 id=5 commit=0", rob.has_no_vacancy, rob.alloc_id, rob.commit_valid); end
   endtask

   // Entry 4 is busy and not ready; entry 6 likewise.
   task automatic test_forwarding();
      rob.query_j_id = 4'd4;
      rob.query_k_id = 4'd0;
      rob.cdb_mem_rob_id = 4'd4; rob.cdb_mem_value = 32'hDEAD;
      #1;
      vectors++; if (rob.query_j_ready !== 1'b1 || rob.query_j_value !== 32'hDEAD) begin errors++; $display("FAIL fwd_mem got ready=%b value=%h want ready=1 value=dead", rob.query_j_ready, rob.query_j_value); end
      vectors++; if (rob.query_k_ready !== 1'b1 || rob.query_k_value !== 32'd0) begin errors++; $display("FAIL fwd_tag0 got ready=%b value=%h want ready=1 value=0", rob.query_k_ready, rob.query_k_value); end
      rob.query_k_id = 4'd6;
      #1;
      vectors++; if (rob.query_k_ready !== 1'b0 || rob.query_k_value !== 32'd0) begin errors++; $display("FAIL fwd_not_ready got ready=%b value=%h want ready=0 value=0", rob.query_k_ready, rob.query_k_value); end
      rob.cdb_alu_rob_id = 4'd4; rob.cdb_alu_value = 32'hBEEF;
      #1;
      vectors++; if (rob.query_j_ready !== 1'b1 || rob.query_j_value !== 32'hBEEF) begin errors++; $display("FAIL fwd_alu_priority got ready=%b value=%h want ready=1 value=beef", rob.query_j_ready, rob.query_j_value); end
      drive_idle();
      rob.query_j_id = 4'd4;
      #1;
      vectors++; if (rob.query_j_ready !== 1'b0) begin errors++; $display("FAIL fwd_busy_unready got ready=%b want 0", rob.query_j_ready); end
      drive_idle();
      step();
   endtask

   task automatic test_flush();
      rob.flush_input = 1'b1;
      step();
      drive_idle();
      vectors++; if (rob.alloc_id !== 4'd1 || rob.has_no_vacancy !== 1'b0 || rob.commit_valid !== 1'b0) begin errors++; $display("FAIL flush_from_full got id=%0d none=%b commit=%b want id=1 none=0 commit=0", rob.alloc_id, rob.has_no_vacancy, rob.commit_valid); end
      for (int i = 0; i < 5; i++) begin
         rob.alloc_valid = 1'b1;
         rob.alloc_rd    = 5'(10 + i);
         step();
      end
      drive_idle();
      rob.cdb_alu_rob_id = 4'd2; rob.cdb_alu_value = 32'h2;
      rob.cdb_mem_rob_id = 4'd3; rob.cdb_mem_value = 32'h3;
      step();
      drive_idle();
      rob.cdb_alu_rob_id = 4'd1; rob.cdb_alu_value = 32'h1;
      step();
      drive_idle();
      rob.flush_input = 1'b1;
      rob.alloc_valid = 1'b1;
      rob.alloc_rd    = 5'd1;
      rob.cdb_alu_rob_id = 4'd4; rob.cdb_alu_value = 32'h4;
      step();
      drive_idle();
      rob.query_j_id = 4'd2;
      rob.query_k_id = 4'd3;
      #1;
      vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL flush_no_commit got %b want 0", rob.commit_valid); end
      vectors++; if (rob.alloc_id !== 4'd1 || rob.has_no_vacancy !== 1'b0 || rob.has_one_vacancy !== 1'b0) begin errors++; $display("FAIL flush_state got id=%0d none=%b one=%b want id=1 none=0 one=0", rob.alloc_id, rob.has_no_vacancy, rob.has_one_vacancy); end
      vectors++; if (rob.query_j_ready !== 1'b0 || rob.query_k_ready !== 1'b0) begin errors++; $display("FAIL flush_lookup got j=%b k=%b want j=0 k=0", rob.query_j_ready, rob.query_k_ready); end
      drive_idle();
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_commit cycle %0d got %b want 0", c, rob.commit_valid); end
      end
   endtask

   // Empty buffer, head=tail=1: alloc and commit overlap on consecutive cycles.
   task automatic test_back_to_back();
      rob.alloc_valid = 1'b1; rob.alloc_rd = 5'd3;
      step();
      rob.alloc_rd = 5'd4;
      rob.cdb_alu_rob_id = 4'd1; rob.cdb_alu_value = 32'hA1;
      step();
      rob.alloc_rd = 5'd8;
      rob.cdb_alu_rob_id = 4'd2; rob.cdb_alu_value = 32'hA2;
      step();
      drive_idle();
      vectors++; if (rob.commit_valid !== 1'b1 || rob.commit_rob_id !== 4'd1 || rob.commit_rd !== 5'd3 || rob.commit_value !== 32'hA1) begin errors++; $display("FAIL b2b_commit1 got v=%b id=%0d rd=%0d val=%h want v=1 id=1 rd=3 val=a1", rob.commit_valid, rob.commit_rob_id, rob.commit_rd, rob.commit_value); end
      vectors++; if (rob.alloc_id !== 4'd4) begin errors++; $display("FAIL b2b_alloc_id got %0d want 4", rob.alloc_id); end
      step();
      vectors++; if (rob.commit_valid !== 1'b1 || rob.commit_rob_id !== 4'd2 || rob.commit_rd !== 5'd4 || rob.commit_value !== 32'hA2) begin errors++; $display("FAIL b2b_commit2 got v=%b id=%0d rd=%0d val=%h want v=1 id=2 rd=4 val=a2", rob.commit_valid, rob.commit_rob_id, rob.commit_rd, rob.commit_value); end
      step();
      vectors++; if (rob.commit_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", rob.commit_valid); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_full();
      test_simultaneous();
      test_forwarding();
      test_flush();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
